// File: rtl/rl_shift_seq.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL/ROR by up to STEP positions per cycle,
// with a valid/ready request port and a valid/ready result port.
module rl_shift_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       shift_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
  localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              loaded_q;
  logic [2:0]        mode_q;
  logic [WIDTH-1:0]  work_q;
  logic [CW-1:0]     rem_q;
  logic [WIDTH-1:0]  result_q;
  logic [CW-1:0]     k_in;
  logic [CW-1:0]     step_amt;
  logic [WIDTH-1:0]  shifted;
  logic              accept;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the producer holds data while valid.
  // loaded_q marks the cycle after accept, spent in IDLE picking SHIFT or DONE.
  assign in_ready  = (state_q == IDLE) && !loaded_q && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign zero      = out_valid && (result_q == '0);
  assign state_dbg = state_q;

  always_comb begin
    k_in = '0;
    case (shift_select)
      3'b000, 3'b001, 3'b010: k_in = (in2 >= WIDTH_W) ? WIDTH_C : CW'(in2);
      3'b011, 3'b100:         k_in = {1'b0, in2[LW-1:0]};
      default:                k_in = '0;
    endcase
  end

  assign step_amt = (rem_q > STEP_C) ? STEP_C : rem_q;

  // Rotates only ever see 0 < step_amt < WIDTH, so WIDTH - step_amt is in range.
  always_comb begin
    shifted = work_q;
    case (mode_q)
      3'b000:  shifted = work_q << step_amt;
      3'b001:  shifted = work_q >> step_amt;
      3'b010:  shifted = $signed(work_q) >>> step_amt;
      3'b011:  shifted = (work_q << step_amt) | (work_q >> (WIDTH_C - step_amt));
      3'b100:  shifted = (work_q >> step_amt) | (work_q << (WIDTH_C - step_amt));
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (loaded_q) state_d = (rem_q != '0) ? SHIFT : DONE;
      SHIFT:   if (rem_q == step_amt) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      mode_q   <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            loaded_q <= 1'b1;
            mode_q   <= shift_select;
            rem_q    <= k_in;
            work_q   <= (shift_select > 3'b100) ? '0 : in1;
          end else if (loaded_q) begin
            loaded_q <= 1'b0;
            if (state_d == DONE) result_q <= work_q;
          end
        end
        SHIFT: begin
          work_q <= shifted;
          rem_q  <= rem_q - step_amt;
          if (state_d == DONE) result_q <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rl_shift_seq.sv
// Directed bench for rl_shift_seq: STEP=1 and STEP=4 instances, hand-computed
// results and latencies, backpressure and mid-operation reset.
module tb_rl_shift_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv1, iv4;
  logic [7:0] in1, in2;
  logic [2:0] shift_select;
  logic       out_ready;

  logic       ir1, ov1, z1, b1;
  logic [7:0] res1;
  logic [1:0] st1;
  logic       ir4, ov4, z4, b4;
  logic [7:0] res4;
  logic [1:0] st4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rl_shift_seq #(.WIDTH(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in1(in1), .in2(in2),
    .shift_select(shift_select), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .zero(z1), .busy(b1), .state_dbg(st1)
  );

  rl_shift_seq #(.WIDTH(8), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in1(in1), .in2(in2),
    .shift_select(shift_select), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .zero(z4), .busy(b4), .state_dbg(st4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cur(input bit sel4, output logic ir, output logic ov,
                     output logic [7:0] res, output logic z);
    ir  = sel4 ? ir4  : ir1;
    ov  = sel4 ? ov4  : ov1;
    res = sel4 ? res4 : res1;
    z   = sel4 ? z4   : z1;
  endtask

  // Present one request; the accept edge is the next posedge.
  task automatic start_op(input bit sel4, input logic [2:0] mode,
                          input logic [7:0] a, input logic [7:0] b);
    logic ir, ov, z;
    logic [7:0] res;
    cur(sel4, ir, ov, res, z);
    check("ready_before_req", 32'(ir), 32'd1);
    shift_select = mode;
    in1 = a;
    in2 = b;
    if (sel4) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic wait_done(input bit sel4, output int lat);
    logic ir, ov, z;
    logic [7:0] res;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      cur(sel4, ir, ov, res, z);
      if (ov) break;
    end
    if (!ov) lat = -1;
  endtask

  task automatic release_out(input bit sel4);
    logic ir, ov, z;
    logic [7:0] res;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cur(sel4, ir, ov, res, z);
    check("after_release_ready", 32'(ir), 32'd1);
  endtask

  task automatic run_op(input string tag, input bit sel4, input logic [2:0] mode,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input int exp_lat);
    int lat;
    logic ir, ov, z;
    logic [7:0] res;
    start_op(sel4, mode, a, b);
    wait_done(sel4, lat);
    cur(sel4, ir, ov, res, z);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(res), 32'(exp));
    check({tag, "_zero"}, 32'(z), 32'(exp == 8'h00));
    release_out(sel4);
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; iv1 = 1'b0; iv4 = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; shift_select = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir1), 32'd0);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_result", 32'(res1), 32'd0);
    check("rst_busy", 32'(b1), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(ir1), 32'd1);

    run_op("sll_1",     1'b0, 3'b000, 8'h03, 8'd1,   8'h06, 2);
    run_op("srl_3",     1'b0, 3'b001, 8'hC0, 8'd3,   8'h18, 4);
    run_op("sra_3",     1'b0, 3'b010, 8'hC0, 8'd3,   8'hF8, 4);
    run_op("sll_8",     1'b0, 3'b000, 8'h03, 8'd8,   8'h00, 9);
    run_op("sll_200",   1'b0, 3'b000, 8'h03, 8'd200, 8'h00, 9);
    run_op("sra_8",     1'b0, 3'b010, 8'h80, 8'd8,   8'hFF, 9);
    run_op("ror_9",     1'b0, 3'b100, 8'h81, 8'd9,   8'hC0, 2);
    run_op("rol_8",     1'b0, 3'b011, 8'h81, 8'd8,   8'h81, 1);
    run_op("rol_7_s4",  1'b1, 3'b011, 8'h12, 8'd7,   8'h09, 3);
    run_op("invalid",   1'b0, 3'b111, 8'h7F, 8'd2,   8'h00, 1);
    run_op("rol_3",     1'b0, 3'b011, 8'h96, 8'd3,   8'hB4, 4);
    run_op("srl_5_s4",  1'b1, 3'b001, 8'hF0, 8'd5,   8'h07, 3);

    // Backpressure: DONE held with a competing request on the input.
    start_op(1'b0, 3'b001, 8'hC0, 8'd3);
    wait_done(1'b0, lat);
    check("bp_latency", 32'(lat), 32'd4);
    iv1 = 1'b1; in1 = 8'h55; in2 = 8'd1; shift_select = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result", 32'(res1), 32'h18);
      check("bp_in_ready", 32'(ir1), 32'd0);
      check("bp_out_valid", 32'(ov1), 32'd1);
    end
    iv1 = 1'b0;
    release_out(1'b0);
    check("bp_out_valid_low", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    check("bp_no_second_accept", 32'(st1), 32'd0);
    check("bp_result_retained", 32'(res1), 32'h18);

    // Reset in the middle of a long SLL.
    start_op(1'b0, 3'b000, 8'h03, 8'd6);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(b1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mrst_state", 32'(st1), 32'd0);
    check("mrst_out_valid", 32'(ov1), 32'd0);
    check("mrst_result", 32'(res1), 32'd0);
    check("mrst_in_ready", 32'(ir1), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov1) seen = 1'b1;
    end
    check("mrst_no_ghost", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
